regfile_reader: RTL and testbench

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_reader.sv | 88 ++++++++
 tb/tb_regfile_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_reader.sv
// Walks a 32x32 register file from first_index to last_index (wrapping 31->0) and
// presents each word with its index on a valid/ready output port.
module regfile_reader (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  first_index,
    input  logic [4:0]  last_index,
    output logic [4:0]  read_index,
    input  logic [31:0] read_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_index,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fsm_state
);

    // Output handshake: a word moves when out_valid & out_ready are both high at
    // posedge; while out_valid is high and out_ready is low, out_data/out_index hold.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] ptr;
    logic [4:0] last_q;
    logic       at_last;

    assign at_last    = (ptr == last_q);
    assign read_index = ptr;
    assign busy       = (state == S_READ) || (state == S_OUT);
    assign done       = (state == S_DONE);
    assign fsm_state  = state;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_READ;
            S_READ: state_next = S_OUT;
            S_OUT: begin
                if (out_ready) state_next = at_last ? S_DONE : S_READ;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= S_IDLE;
            ptr       <= 5'd0;
            last_q    <= 5'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_index <= 5'd0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr    <= first_index;
                        last_q <= last_index;
                    end
                end
                S_READ: begin
                    out_data  <= read_value;
                    out_index <= ptr;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // 5-bit increment wraps 31 -> 0 for ranges with first > last
                        if (!at_last) ptr <= ptr + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: a behavioural register-file model feeds
// read_value, dumps are expected as (index, data) lists, a monitor checks transfers.
module tb_regfile_reader;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [4:0]  first_index;
    logic [4:0]  last_index;
    logic [4:0]  read_index;
    logic [31:0] read_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        busy;
    logic        done;
    logic [1:0]  fsm_state;

    regfile_reader dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .first_index (first_index),
        .last_index  (last_index),
        .read_index  (read_index),
        .read_value  (read_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .busy        (busy),
        .done        (done),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / register file model ----------------
    always #5 clock = ~clock;

    logic [31:0] rf [32];
    assign read_value = rf[read_index];

    int checks = 0;
    int errors = 0;

    // entry = {final_word, index, data}
    logic [37:0] exp_q[$];
    logic [37:0] exp_e;
    int          ready_mode;   // 0 random, 1 always high, 2 driven by the test
    bit          done_due;
    bit          stalled;
    logic [31:0] held_data;
    logic [4:0]  held_index;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
            else if (ready_mode == 1) out_ready = 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        done_due = 0;
        stalled  = 0;
        forever begin
            @(negedge clock);
            if (!clear) begin
                check("done_pulse", {31'd0, done}, {31'd0, done_due});
                done_due = 0;
                if (out_valid) begin
                    check("valid_implies_busy", {31'd0, busy}, 32'd1);
                    check("read_index_tracks", {27'd0, read_index}, {27'd0, out_index});
                end
                if (stalled && out_valid) begin
                    check("stall_data", out_data, held_data);
                    check("stall_index", {27'd0, out_index}, {27'd0, held_index});
                end
                stalled    = out_valid && !out_ready;
                held_data  = out_data;
                held_index = out_index;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word index=%0d data=%0d expected=none", out_index, out_data);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("word_index", {27'd0, out_index}, {27'd0, exp_e[36:32]});
                        check("word_data", out_data, exp_e[31:0]);
                        if (exp_e[37]) done_due = 1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout busy=%0d expected=0", busy);
        end
    endtask

    // Model: a dump covers ((last-first) mod 32)+1 consecutive indices, wrapping at 32.
    task automatic issue(input logic [4:0] f, input logic [4:0] l, input bit scramble);
        int         words;
        logic [4:0] idx;
        wait_idle();
        words = ((int'(l) - int'(f) + 32) % 32) + 1;
        for (int k = 0; k < words; k++) begin
            idx = 5'((int'(f) + k) % 32);
            exp_q.push_back({(k == words - 1), idx, rf[idx]});
        end
        first_index = f;
        last_index  = l;
        start       = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (scramble) begin
            first_index = 5'($urandom);
            last_index  = 5'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain timeout remaining=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) begin
            @(posedge clock);
            #1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        clear       = 1'b1;
        start       = 1'b0;
        first_index = 5'd0;
        last_index  = 5'd0;
        out_ready   = 1'b0;
        ready_mode  = 2;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 100);

        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_read_index", {27'd0, read_index}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_index", {27'd0, out_index}, 32'd0);
        clear = 1'b0;

        // simple range and wrapping range
        ready_mode = 1;
        issue(5'd3, 5'd5, 0);
        drain();
        issue(5'd30, 5'd1, 0);
        drain();

        // single word with a five-cycle stall
        ready_mode = 2;
        out_ready  = 1'b0;
        issue(5'd7, 5'd7, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("stall_valid_rise", {31'd0, out_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            check("stall_hold_data", out_data, 32'd700);
            check("stall_hold_index", {27'd0, out_index}, 32'd7);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // start pulses while busy are ignored
        ready_mode = 0;
        issue(5'd10, 5'd14, 1);
        for (int p = 0; p < 3; p++) begin
            first_index = 5'd0;
            last_index  = 5'd0;
            start       = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
            @(posedge clock);
            #1;
        end
        drain();

        // full 32-word dump at full rate: done arrives 64 cycles after READ entry
        ready_mode = 1;
        issue(5'd0, 5'd31, 0);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("full_dump_cycles", 32'(n), 32'd64);
        drain();

        // clear in the OUT state of the second word aborts the dump
        ready_mode = 2;
        out_ready  = 1'b1;
        issue(5'd0, 5'd31, 0);
        n = 0;
        while (!(out_valid && out_index == 5'd1) && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("abort_reached_word1", {27'd0, out_index}, 32'd1);
        out_ready = 1'b0;
        clear     = 1'b1;
        @(posedge clock);
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_read_index", {27'd0, read_index}, 32'd0);
        clear = 1'b0;
        exp_q.delete();
        done_due = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        ready_mode = 1;
        issue(5'd2, 5'd2, 0);
        drain();

        // randomized contents, ranges and back-pressure
        ready_mode = 0;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
